march_bist_ctrl: RTL and testbench

- Parametrised March C- memory BIST controller; successor to the single-bit mem_FSM.
- Integrates the address up/down counter and the data comparator that mem_FSM drove externally through reset/preset/en/up_down/carry/is_equal.
- Drives a synchronous single-port RAM (1-cycle read latency) directly.
- Reports pass/fail with first-fail diagnostics and a fail count; selectable stop-on-first-fail mode.

---
 rtl/march_bist_ctrl.sv | 168 ++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller driving a single-port synchronous RAM (1-cycle read latency).
// Internal address counter and comparator; first-fail diagnostics, saturating fail count.
module march_bist_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              stop_on_fail_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fail_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [2:0]        fail_elem_o,
   output logic [DATA_W-1:0] fail_syn_o,
   output logic [CNT_W-1:0]  fail_count_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_W_ONLY   = 3'd1;
   localparam logic [2:0] S_RD       = 3'd2;
   localparam logic [2:0] S_CMP_WR   = 3'd3;
   localparam logic [2:0] S_CMP_ONLY = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [2:0]        ELEM_LAST = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              stop_q, stop_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]        fail_elem_q, fail_elem_d;
   logic [DATA_W-1:0] fail_syn_q, fail_syn_d;
   logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;

   logic              down;
   logic              addr_last;
   logic [DATA_W-1:0] exp_bg;
   logic [DATA_W-1:0] syndrome;
   logic              mismatch;
   logic [2:0]        next_elem;
   logic [ADDR_W-1:0] next_start_addr;

   // E3/E4 walk downwards; E2/E4 expect the all-ones background
   assign down            = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign addr_last       = down ? (addr_q == '0) : (addr_q == ADDR_LAST);
   assign exp_bg          = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
   assign syndrome        = mem_rdata_i ^ exp_bg;
   assign mismatch        = ((state_q == S_CMP_WR) || (state_q == S_CMP_ONLY)) && (syndrome != '0);
   assign next_elem       = elem_q + 3'd1;
   assign next_start_addr = ((next_elem == 3'd3) || (next_elem == 3'd4)) ? ADDR_LAST : '0;

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      addr_d      = addr_q;
      stop_d      = stop_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_syn_d  = fail_syn_q;
      fail_cnt_d  = fail_cnt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_W_ONLY;
               elem_d      = 3'd0;
               addr_d      = '0;
               stop_d      = stop_on_fail_i;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 3'd0;
               fail_syn_d  = '0;
               fail_cnt_d  = '0;
            end
         end
         S_W_ONLY: begin
            if (addr_last) begin
               elem_d  = 3'd1;
               addr_d  = '0;
               state_d = S_RD;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_RD: begin
            state_d = (elem_q == ELEM_LAST) ? S_CMP_ONLY : S_CMP_WR;
         end
         S_CMP_WR, S_CMP_ONLY: begin
            if (mismatch) begin
               if (fail_cnt_q != '1) begin
                  fail_cnt_d = fail_cnt_q + 1'b1;
               end
               if (!fail_q) begin
                  fail_d      = 1'b1;
                  fail_addr_d = addr_q;
                  fail_elem_d = elem_q;
                  fail_syn_d  = syndrome;
               end
            end
            // the pending write of this cycle still happens; only sequencing stops
            if (mismatch && stop_q) begin
               state_d = S_DONE;
            end else if (addr_last) begin
               if (elem_q == ELEM_LAST) begin
                  state_d = S_DONE;
               end else begin
                  elem_d  = next_elem;
                  addr_d  = next_start_addr;
                  state_d = S_RD;
               end
            end else begin
               addr_d  = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         addr_q      <= '0;
         stop_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
         fail_syn_q  <= '0;
         fail_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         stop_q      <= stop_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_syn_q  <= fail_syn_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign mem_addr_o   = addr_q;
   assign mem_we_o     = (state_q == S_W_ONLY) || (state_q == S_CMP_WR);
   assign mem_re_o     = (state_q == S_RD);
   assign mem_wdata_o  = (state_q == S_CMP_WR) ? ~exp_bg : '0;
   assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o       = (state_q == S_DONE);
   assign fail_o       = fail_q;
   assign fail_addr_o  = fail_addr_q;
   assign fail_elem_o  = fail_elem_q;
   assign fail_syn_o   = fail_syn_q;
   assign fail_count_o = fail_cnt_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Bench for march_bist_ctrl: faulty-RAM model plus a loop-level March C- reference
// giving the expected operation trace, completion cycle and diagnostics.
module tb_march_bist_ctrl;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              stop_on_fail;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              done;
   logic              fail;
   logic [ADDR_W-1:0] fail_addr;
   logic [2:0]        fail_elem;
   logic [DATA_W-1:0] fail_syn;
   logic [CNT_W-1:0]  fail_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_on_fail_i(stop_on_fail),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_re_o(mem_re),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .done_o(done), .fail_o(fail), .fail_addr_o(fail_addr),
      .fail_elem_o(fail_elem), .fail_syn_o(fail_syn), .fail_count_o(fail_count)
   );

   // RAM with one optional stuck-at fault applied on the read path
   logic [DATA_W-1:0] ram [DEPTH];
   logic              fault_en   = 1'b0;
   logic [ADDR_W-1:0] fault_addr = '0;
   logic [DATA_W-1:0] fault_mask = '0;
   logic              fault_sa1  = 1'b0;

   function automatic logic [DATA_W-1:0] faulty(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
      if (fault_en && a == fault_addr)
         return fault_sa1 ? (v | fault_mask) : (v & ~fault_mask);
      return v;
   endfunction

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= faulty(mem_addr, ram[mem_addr]);
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] op_word(input logic we, input logic re,
                                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      logic [31:0] w;
      w = '0;
      w[DATA_W-1:0]            = we ? d : '0;
      w[DATA_W +: ADDR_W]      = a;
      w[DATA_W + ADDR_W]       = re;
      w[DATA_W + ADDR_W + 1]   = we;
      return w;
   endfunction

   // Reference: March C- walked with plain loops over an abstract memory
   logic [31:0]       exp_ops[$];
   int                exp_cycles, exp_cnt, exp_we_n, exp_re_n;
   logic              exp_fail;
   logic [ADDR_W-1:0] exp_faddr;
   logic [2:0]        exp_felem;
   logic [DATA_W-1:0] exp_fsyn;

   task automatic build_model(input bit stop);
      logic [DATA_W-1:0] m [DEPTH];
      logic [DATA_W-1:0] bg, rd;
      logic [ADDR_W-1:0] av;
      bit                dn;
      exp_ops.delete();
      exp_cycles = 0; exp_cnt = 0; exp_we_n = 0; exp_re_n = 0;
      exp_fail = 1'b0; exp_faddr = '0; exp_felem = 3'd0; exp_fsyn = '0;
      for (int i = 0; i < DEPTH; i++) begin
         av = ADDR_W'(i);
         exp_ops.push_back(op_word(1'b1, 1'b0, av, '0));
         m[i] = '0;
         exp_cycles++; exp_we_n++;
      end
      for (int e = 1; e <= 5; e++) begin
         dn = (e == 3 || e == 4);
         bg = (e == 2 || e == 4) ? '1 : '0;
         for (int i = 0; i < DEPTH; i++) begin
            av = dn ? ADDR_W'(DEPTH - 1 - i) : ADDR_W'(i);
            exp_ops.push_back(op_word(1'b0, 1'b1, av, '0));
            exp_re_n++;
            rd = faulty(av, m[av]);
            exp_cycles += 2;
            if (rd != bg) begin
               if (exp_cnt < 2 ** CNT_W - 1) exp_cnt++;
               if (!exp_fail) begin
                  exp_fail = 1'b1; exp_faddr = av; exp_felem = 3'(e); exp_fsyn = rd ^ bg;
               end
            end
            if (e < 5) begin
               exp_ops.push_back(op_word(1'b1, 1'b0, av, ~bg));
               m[av] = ~bg;
               exp_we_n++;
            end
            if (rd != bg && stop) return;
         end
      end
   endtask

   int last_k;

   task automatic run_test(input string name, input bit stop, input int restart_k, input int abort_k);
      int          k, we_n, re_n;
      bit          finished;
      logic [31:0] obs;
      build_model(stop);
      @(negedge clk);
      start = 1'b1; stop_on_fail = stop;
      @(posedge clk);
      k = 0; we_n = 0; re_n = 0; finished = 0;
      while (k < 400) begin
         @(negedge clk);
         if (done) begin finished = 1; break; end
         start = (k == restart_k);
         stop_on_fail = 1'($urandom_range(0, 1));
         if (k == 0) begin
            check_val({name, ":busy_at_T"}, 32'(busy), 32'd1);
            check_val({name, ":fail_clr"}, 32'(fail), 32'd0);
            check_val({name, ":cnt_clr"}, 32'(fail_count), 32'd0);
            check_val({name, ":syn_clr"}, 32'(fail_syn), 32'd0);
         end
         if (k == abort_k) begin
            start = 1'b0;
            rst = 1'b1;
            #1;
            check_val({name, ":rst_busy"}, 32'(busy), 32'd0);
            check_val({name, ":rst_done"}, 32'(done), 32'd0);
            check_val({name, ":rst_strobes"}, 32'({mem_we, mem_re}), 32'd0);
            check_val({name, ":rst_addr"}, 32'(mem_addr), 32'd0);
            check_val({name, ":rst_wdata"}, 32'(mem_wdata), 32'd0);
            check_val({name, ":rst_diag"}, 32'({fail, fail_addr, fail_elem, fail_syn, fail_count}), 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            $display("run %s: reset applied at cycle %0d, run abandoned", name, k);
            return;
         end
         if (mem_we || mem_re) begin
            we_n += 32'(mem_we); re_n += 32'(mem_re);
            obs = op_word(mem_we, mem_re, mem_addr, mem_wdata);
            if (exp_ops.size() == 0) check_val({name, ":extra_op"}, obs, 32'd0);
            else check_val({name, ":op"}, obs, exp_ops.pop_front());
         end
         @(posedge clk);
         k++;
      end
      start = 1'b0;
      last_k = k;
      check_val({name, ":done_seen"}, 32'(finished), 32'd1);
      check_val({name, ":done_cycle"}, 32'(k), 32'(exp_cycles));
      check_val({name, ":busy_end"}, 32'(busy), 32'd0);
      check_val({name, ":ops_left"}, 32'(exp_ops.size()), 32'd0);
      check_val({name, ":we_n"}, 32'(we_n), 32'(exp_we_n));
      check_val({name, ":re_n"}, 32'(re_n), 32'(exp_re_n));
      check_val({name, ":fail"}, 32'(fail), 32'(exp_fail));
      check_val({name, ":count"}, 32'(fail_count), 32'(exp_cnt));
      check_val({name, ":faddr"}, 32'(fail_addr), 32'(exp_faddr));
      check_val({name, ":felem"}, 32'(fail_elem), 32'(exp_felem));
      check_val({name, ":fsyn"}, 32'(fail_syn), 32'(exp_fsyn));
      @(negedge clk);
      check_val({name, ":quiet_after"}, 32'({mem_we, mem_re, done}), 32'b001);
      $display("run %s: stop=%0d done at %0d fail=%0d count=%0d addr=%0d elem=%0d syn=%02h",
               name, stop, k, fail, fail_count, fail_addr, fail_elem, fail_syn);
   endtask

   task automatic set_fault(input logic en, input int a, input int bitpos, input logic sa1);
      fault_en = en; fault_addr = ADDR_W'(a); fault_sa1 = sa1;
      fault_mask = '0; fault_mask[bitpos] = 1'b1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset:busy_done", 32'({busy, done}), 32'd0);
      check_val("reset:strobes", 32'({mem_we, mem_re}), 32'd0);
      check_val("reset:diag", 32'({fail, fail_addr, fail_elem, fail_syn, fail_count}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      set_fault(1'b0, 0, 0, 1'b0);
      run_test("clean", 1'b0, 60, -1);
      check_val("clean:done176", 32'(last_k), 32'd176);
      check_val("clean:fail", 32'(fail), 32'd0);

      set_fault(1'b1, 5, 0, 1'b1);
      run_test("sa1_b0_a5", 1'b0, -1, -1);
      check_val("sa1:count3", 32'(fail_count), 32'd3);
      check_val("sa1:diag", 32'({fail_addr, fail_elem, fail_syn}), 32'({4'd5, 3'd1, 8'h01}));

      run_test("sa1_stop", 1'b1, -1, -1);
      check_val("sa1_stop:done28", 32'(last_k), 32'd28);
      check_val("sa1_stop:count1", 32'(fail_count), 32'd1);

      set_fault(1'b1, 0, 7, 1'b0);
      run_test("sa0_b7_a0", 1'b0, -1, -1);
      check_val("sa0:diag", 32'({fail_addr, fail_elem, fail_syn}), 32'({4'd0, 3'd2, 8'h80}));
      check_val("sa0:count2", 32'(fail_count), 32'd2);

      set_fault(1'b0, 0, 0, 1'b0);
      run_test("abort", 1'b0, -1, 50);
      run_test("after_rst", 1'b0, -1, -1);
      check_val("after_rst:done176", 32'(last_k), 32'd176);

      for (int r = 0; r < 8; r++) begin
         set_fault(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, DATA_W - 1)), 1'($urandom_range(0, 1)));
         run_test($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                  int'($urandom_range(5, 170)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
